// File: rtl/alu_seq.sv
// alu_seq: two-phase sequenced ALU/microcode emitter; define ALU_SEQ_FLAGS_EN to enable {carry,zero} flags.
module alu_seq #(
  parameter int DATA_W = 32,
  parameter int STACK_STEP = 1,
  parameter int RET_CODE = 5,
  parameter int CALL_CODE = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       ope,
  input  logic [DATA_W-1:0] immidiate_data,
  input  logic [DATA_W-1:0] registor_in,
  output logic [DATA_W-1:0] alu_result_bus,
  output logic              busy,
  output logic              result_valid,
  output logic [1:0]        phase,
  output logic              done,
  output logic              illegal,
  output logic [1:0]        flags
);
  typedef enum logic [1:0] {IDLE = 2'd0, PH1 = 2'd1, PH2 = 2'd2} state_t;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);
  localparam logic [DATA_W-1:0] RET_V = DATA_W'(RET_CODE);
  localparam logic [DATA_W-1:0] CALL_V = DATA_W'(CALL_CODE);
  state_t state;
  logic [31:0] op;
  logic [7:0] opc;
  logic [DATA_W-1:0] res1, res2;
  logic two_ph, arith;
  function automatic logic is_legal(input logic [7:0] o);
    return o == 8'h55 || o == 8'h5d || o == 8'h89 || o == 8'hb8 || o == 8'hc3 ||
           o == 8'he8 || o == 8'h01 || o == 8'h29 || o == 8'h31;
  endfunction
  assign opc = op[31:24];
  assign busy = state != IDLE;
  assign phase = state;
  always_comb begin
    two_ph = opc == 8'h55 || opc == 8'h5d || opc == 8'hb8 || opc == 8'hc3 || opc == 8'he8;
    arith = opc == 8'h01 || opc == 8'h29 || opc == 8'h31;
    res1 = '0;
    res2 = '0;
    case (opc)
      8'h55: begin res1 = registor_in - STEP; res2 = registor_in; end
      8'h5d: begin res1 = registor_in; res2 = registor_in + STEP; end
      8'h89: res1 = registor_in;
      8'hb8: begin res1 = DATA_W'({op[7:0], op[15:8], op[23:16]}); res2 = DATA_W'(3); end
      8'hc3: begin res1 = RET_V; res2 = RET_V; end
      8'he8: begin res1 = CALL_V; res2 = CALL_V; end
      8'h01: res1 = registor_in + immidiate_data;
      8'h29: res1 = registor_in - immidiate_data;
      8'h31: res1 = registor_in ^ immidiate_data;
      default: ;
    endcase
  end
`ifdef ALU_SEQ_FLAGS_EN
  logic [DATA_W:0] add_w;
  logic cy;
  logic [1:0] flags_q;
  assign add_w = {1'b0, registor_in} + {1'b0, immidiate_data};
  assign cy = opc == 8'h01 ? add_w[DATA_W] : opc == 8'h29 ? registor_in < immidiate_data : 1'b0;
  assign flags = flags_q;
`else
  assign flags = 2'b00;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op <= '0;
      alu_result_bus <= '0;
      result_valid <= 1'b0;
      done <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q <= 2'b00;
`endif
    end else begin
      result_valid <= 1'b0;
      done <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op <= ope;
          state <= PH1;
          illegal <= !is_legal(ope[31:24]);
        end
        PH1: begin
          state <= is_legal(opc) && two_ph ? PH2 : IDLE;
          if (is_legal(opc)) begin
            alu_result_bus <= res1;
            result_valid <= 1'b1;
            done <= !two_ph;
`ifdef ALU_SEQ_FLAGS_EN
            if (arith) flags_q <= {cy, res1 == '0};
`endif
          end
        end
        PH2: begin
          alu_result_bus <= res2;
          result_valid <= 1'b1;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifndef ALU_SEQ_FLAGS_EN
  logic unused;
  assign unused = arith;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed expectations for alu_seq (DATA_W=32, defaults).
module tb_alu_seq;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [31:0] ope = '0, immidiate_data = '0, registor_in = '0, alu_result_bus;
  logic busy, result_valid, done, illegal;
  logic [1:0] phase, flags;
  int vectors = 0, errs = 0;
`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  alu_seq dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ope(ope),
    .immidiate_data(immidiate_data), .registor_in(registor_in),
    .alu_result_bus(alu_result_bus), .busy(busy), .result_valid(result_valid),
    .phase(phase), .done(done), .illegal(illegal), .flags(flags)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the whole output set in one call: result, valid, done, busy, phase, illegal.
  task automatic chk_all(input string tag, input logic [31:0] r, input logic v, input logic d,
                         input logic b, input logic [1:0] p, input logic il);
    chk({tag, ".result"}, 64'(alu_result_bus), 64'(r));
    chk({tag, ".valid"}, 64'(result_valid), 64'(v));
    chk({tag, ".done"}, 64'(done), 64'(d));
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".phase"}, 64'(phase), 64'(p));
    chk({tag, ".illegal"}, 64'(illegal), 64'(il));
  endtask

  initial begin
    step;
    chk_all("reset", 32'h0, 0, 0, 0, 2'd0, 0);
    chk("reset.flags", 64'(flags), 64'd0);
    reset_n = 1'b1;
    step;
    // push with start held high throughout and ope swapped to mov: must stay a push
    start = 1'b1; ope = 32'h5500_0000; registor_in = 32'h100;
    step;
    ope = 32'h8900_0000;
    chk_all("push.ph1", 32'h0, 0, 0, 1, 2'd1, 0);
    step;
    chk_all("push.r1", 32'hFF, 1, 0, 1, 2'd2, 0);
    step;
    start = 1'b0;
    chk_all("push.r2", 32'h100, 1, 1, 0, 2'd0, 0);
    step;
    chk_all("push.after", 32'h100, 0, 0, 0, 2'd0, 0);
    // mov-imm byte-swapped immediate
    start = 1'b1; ope = 32'hB812_3456;
    step;
    start = 1'b0;
    step;
    chk_all("movi.r1", 32'h0056_3412, 1, 0, 1, 2'd2, 0);
    step;
    chk_all("movi.r2", 32'h3, 1, 1, 0, 2'd0, 0);
    // add wrap to zero with carry
    start = 1'b1; ope = 32'h0100_0000; registor_in = 32'hFFFF_FFFF; immidiate_data = 32'h1;
    step;
    start = 1'b0;
    step;
    chk_all("add.r1", 32'h0, 1, 1, 0, 2'd0, 0);
    chk("add.flags", 64'(flags), FEN ? 64'd3 : 64'd0);
    // xor gives a nonzero prior value for the illegal test
    start = 1'b1; ope = 32'h3100_0000; registor_in = 32'hF0F0; immidiate_data = 32'h0FF0;
    step;
    start = 1'b0;
    step;
    chk_all("xor.r1", 32'hFF00, 1, 1, 0, 2'd0, 0);
    chk("xor.flags", 64'(flags), 64'd0);
    start = 1'b1; ope = 32'hFF00_0000;
    step;
    start = 1'b0;
    chk_all("ill.ph1", 32'hFF00, 0, 0, 1, 2'd1, 1);
    step;
    chk_all("ill.after", 32'hFF00, 0, 0, 0, 2'd0, 0);
    chk("ill.flags", 64'(flags), 64'd0);
    // sub with borrow
    start = 1'b1; ope = 32'h2900_0000; registor_in = 32'h5; immidiate_data = 32'h7;
    step;
    start = 1'b0;
    step;
    chk_all("sub.r1", 32'hFFFF_FFFE, 1, 1, 0, 2'd0, 0);
    chk("sub.flags", 64'(flags), FEN ? 64'd2 : 64'd0);
    // pop at all-ones wraps to zero
    start = 1'b1; ope = 32'h5D00_0000; registor_in = 32'hFFFF_FFFF;
    step;
    start = 1'b0;
    step;
    chk_all("pop.r1", 32'hFFFF_FFFF, 1, 0, 1, 2'd2, 0);
    step;
    chk_all("pop.r2", 32'h0, 1, 1, 0, 2'd0, 0);
    // ret, then call started in the cycle done is visible
    start = 1'b1; ope = 32'hC300_0000;
    step;
    start = 1'b0;
    step;
    chk_all("ret.r1", 32'h5, 1, 0, 1, 2'd2, 0);
    step;
    chk_all("ret.r2", 32'h5, 1, 1, 0, 2'd0, 0);
    start = 1'b1; ope = 32'hE800_0000;
    step;
    start = 1'b0;
    chk_all("call.ph1", 32'h5, 0, 0, 1, 2'd1, 0);
    step;
    chk_all("call.r1", 32'h6, 1, 0, 1, 2'd2, 0);
    step;
    chk_all("call.r2", 32'h6, 1, 1, 0, 2'd0, 0);
    // mov single phase
    start = 1'b1; ope = 32'h8900_0000; registor_in = 32'h1234_5678;
    step;
    start = 1'b0;
    step;
    chk_all("mov.r1", 32'h1234_5678, 1, 1, 0, 2'd0, 0);
    // asynchronous reset in PH1 of pop
    start = 1'b1; ope = 32'h5D00_0000; registor_in = 32'h40;
    step;
    start = 1'b0;
    chk_all("rst.ph1", 32'h1234_5678, 0, 0, 1, 2'd1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk_all("rst.async", 32'h0, 0, 0, 0, 2'd0, 0);
    chk("rst.flags", 64'(flags), 64'd0);
    step;
    reset_n = 1'b1;
    step;
    step;
    chk_all("rst.noresume", 32'h0, 0, 0, 0, 2'd0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
